// File: rtl/cpu_traffic_master_pkg.sv
// ============================================================================
// Package  : cache_definition
// Purpose  : CPU/cache port types, LFSR taps and traffic-master state codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_definition;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;     // 1 = write
        logic        valid;
    } cpu_to_cache_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cache_to_cpu_type;

    localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;

    typedef logic [2:0] tm_state_t;
    localparam tm_state_t c_IDLE   = 3'd0;
    localparam tm_state_t c_LAUNCH = 3'd1;
    localparam tm_state_t c_ISSUE  = 3'd2;
    localparam tm_state_t c_GAP    = 3'd3;
    localparam tm_state_t c_DONE   = 3'd4;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? c_LFSR_TAPS : 32'h0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tm_lfsr32.sv
// ============================================================================
// Module   : tm_lfsr32
// Purpose  : 32-bit Galois LFSR with seed load (zero seed maps to 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tm_lfsr32
    import cache_definition::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        enable,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    logic [31:0] r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= 32'h0000_0001;
        end else if (load) begin
            r_value <= (seed == 32'h0) ? 32'h0000_0001 : seed;
        end else if (enable) begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/cpu_traffic_master.sv
// ============================================================================
// Module   : cpu_traffic_master
// Purpose  : Self-checking pseudo-random CPU-port initiator with shadow memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_traffic_master
    import cache_definition::*;
#(
    parameter int          NUM_TXN   = 256,
    parameter int          WIN_AW    = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed,
    input  cache_to_cpu_type cache_to_cpu,
    output cpu_to_cache_type cpu_to_cache,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [15:0]      err_count,
    output logic [15:0]      txn_count
);

    localparam int c_WORDS = 2 ** WIN_AW;
    localparam int c_WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    tm_state_t        r_state;
    cpu_to_cache_type r_req;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;
    logic [15:0]      r_err;
    logic [15:0]      r_txn;
    logic [c_WD_W-1:0] r_wd;
    logic [WIN_AW-1:0] r_idx;
    logic [31:0]       r_shadow [c_WORDS];
    logic [c_WORDS-1:0] r_shadow_vld;

    logic              w_start_ok;
    logic [31:0]       w_lfsr;
    logic [31:0]       w_l;
    logic [WIN_AW-1:0] w_new_idx;
    logic              w_mismatch;
    logic              w_wr_done;

    assign w_start_ok = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_l        = lfsr_next(w_lfsr);
    assign w_new_idx  = w_l[WIN_AW-1:0];
    assign w_wr_done  = (r_state == c_ISSUE) && cache_to_cpu.ready && r_req.rw;
    // Reads of words never written in this run are deliberately unchecked.
    assign w_mismatch = r_shadow_vld[r_idx] && (cache_to_cpu.data != r_shadow[r_idx]);

    tm_lfsr32 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (w_start_ok),
        .enable (r_state == c_LAUNCH),
        .seed   (seed),
        .value  (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_req        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_err        <= '0;
            r_txn        <= '0;
            r_wd         <= '0;
            r_idx        <= '0;
            r_shadow_vld <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state      <= c_LAUNCH;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_err        <= '0;
                        r_txn        <= '0;
                        r_shadow_vld <= '0;
                    end
                end
                c_LAUNCH: begin
                    r_req.addr  <= BASE_ADDR + 32'({w_new_idx, 2'b00});
                    r_req.rw    <= w_l[31];
                    r_req.data  <= w_l[31] ? {w_l[15:0], w_l[31:16]} : 32'h0;
                    r_req.valid <= 1'b1;
                    r_idx       <= w_new_idx;
                    r_wd        <= '0;
                    r_state     <= c_ISSUE;
                end
                c_ISSUE: begin
                    if (cache_to_cpu.ready) begin
                        r_req.valid <= 1'b0;
                        r_txn       <= r_txn + 16'd1;
                        if (r_req.rw) begin
                            r_shadow_vld[r_idx] <= 1'b1;
                        end else if (w_mismatch && (r_err != 16'hFFFF)) begin
                            r_err <= r_err + 16'd1;
                        end
                        r_state <= c_GAP;
                    end else if (r_wd == c_WD_LAST) begin
                        r_req.valid <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_state     <= c_DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                c_GAP: begin
                    if (r_txn == 16'(NUM_TXN)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err == 16'h0);
                        r_state <= c_DONE;
                    end else begin
                        r_state <= c_LAUNCH;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Shadow data needs no reset: it is only trusted where the valid bit is set.
    always_ff @(posedge clk) begin
        if (w_wr_done) begin
            r_shadow[r_idx] <= r_req.data;
        end
    end

    assign cpu_to_cache = r_req;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign timeout      = r_timeout;
    assign err_count    = r_err;
    assign txn_count    = r_txn;

endmodule

`default_nettype wire

// File: tb/tb_cpu_traffic_master.sv
// ============================================================================
// Module   : tb_cpu_traffic_master
// Purpose  : Directed self-checking bench with a stub cache responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_traffic_master;
    import cache_definition::*;

    localparam int          c_NUM_TXN = 24;
    localparam logic [31:0] c_BASE    = 32'h0000_1000;
    localparam int          c_M_DELAY   = 0;
    localparam int          c_M_CORRUPT = 1;
    localparam int          c_M_NEVER   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      seed_in;
    cache_to_cpu_type c2c;
    cpu_to_cache_type c2m;
    logic             busy, done, pass, timeout;
    logic [15:0]      err_count, txn_count;

    int n_cmp = 0;
    int n_err = 0;
    int mode;
    int exp_err;
    int total_exp = 0;
    int gap_cnt;
    int cnt;
    bit in_req;
    bit had_req;
    logic [31:0] mem [8];
    logic [7:0]  written;
    logic [31:0] offs;
    cpu_to_cache_type lat;
    cpu_to_cache_type req_q [$];

    cpu_traffic_master #(
        .NUM_TXN   (c_NUM_TXN),
        .WIN_AW    (3),
        .BASE_ADDR (c_BASE),
        .TIMEOUT   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed_in),
        .cache_to_cpu (c2c),
        .cpu_to_cache (c2m),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .err_count    (err_count),
        .txn_count    (txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] s);
        exp_err = 0;
        written = '0;
        had_req = 1'b0;
        req_q.delete();
        start   = 1'b1;
        seed_in = s;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done, 1);
    endtask

    // Stub responder: ready pulses on the third cycle of valid.
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        cnt = 0; in_req = 1'b0; had_req = 1'b0; gap_cnt = 0;
        forever begin
            @(negedge clk);
            c2c.ready = 1'b0;
            c2c.data  = '0;
            if (rst) begin
                cnt = 0; in_req = 1'b0; had_req = 1'b0; gap_cnt = 0;
            end else if (c2m.valid) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    cnt    = 0;
                    lat    = c2m;
                    req_q.push_back(c2m);
                    if (had_req) check("gap_cycles", gap_cnt, 2);
                    gap_cnt = 0;
                end else begin
                    check("req_stable", {c2m.addr, c2m.data, c2m.rw},
                          {lat.addr, lat.data, lat.rw});
                end
                cnt++;
                if (mode != c_M_NEVER && cnt == 3) begin
                    c2c.ready = 1'b1;
                    offs = c2m.addr - c_BASE;
                    if (c2m.rw) begin
                        mem[offs[4:2]]     = c2m.data;
                        written[offs[4:2]] = 1'b1;
                    end else begin
                        c2c.data = mem[offs[4:2]] ^ ((mode == c_M_CORRUPT) ? 32'h1 : 32'h0);
                        if (mode == c_M_CORRUPT && written[offs[4:2]]) exp_err++;
                    end
                    in_req  = 1'b0;
                    had_req = 1'b1;
                end
            end else if (had_req) begin
                gap_cnt++;
            end
        end
    end

    initial begin
        logic [31:0] seeds [4];
        int n;
        seeds[0] = 32'h0000_ACE1; seeds[1] = 32'h1234_5678;
        seeds[2] = 32'hDEAD_BEEF; seeds[3] = 32'h0BAD_F00D;
        rst = 1'b1; start = 1'b0; seed_in = '0; mode = c_M_DELAY; exp_err = 0; written = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_c2m", c2m, 66'h0);
        check("rst_flags", {busy, done, pass, timeout}, 4'b0000);
        check("rst_counts", {err_count, txn_count}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Directed run, seed 1: hand-computed first requests
        pulse_start(32'h1);
        check("launch_busy", busy, 1);
        check("launch_valid", c2m.valid, 0);
        @(negedge clk);
        check("issue_valid", c2m.valid, 1);
        n = 0;
        while (req_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
        start = 1'b1; seed_in = 32'h5555_5555;   // must be ignored while busy
        @(negedge clk);
        start = 1'b0;
        wait_done(1000);
        check("runA_nreq", req_q.size(), c_NUM_TXN);
        check("runA_req0", {req_q[0].addr, req_q[0].data, req_q[0].rw}, {32'h0000_100C, 32'h0003_8020, 1'b1});
        check("runA_req1", {req_q[1].addr, req_q[1].data, req_q[1].rw}, {32'h0000_1008, 32'h0002_C030, 1'b1});
        check("runA_req2", {req_q[2].addr, req_q[2].data, req_q[2].rw}, {32'h0000_1004, 32'h0000_0000, 1'b0});
        check("runA_req3", {req_q[3].addr, req_q[3].data, req_q[3].rw}, {32'h0000_100C, 32'h0003_B02C, 1'b1});
        check("runA_txn", txn_count, c_NUM_TXN);
        check("runA_flags", {busy, pass, timeout, c2m.valid}, 4'b0100);
        check("runA_err", err_count, 0);

        // Corrupted read data over several seeds
        mode = c_M_CORRUPT;
        for (int k = 0; k < 4; k++) begin
            pulse_start(seeds[k]);
            wait_done(1000);
            total_exp += exp_err;
            check("corrupt_err", err_count, exp_err);
            check("corrupt_pass", pass, (exp_err == 0));
        end
        check("corrupt_any", (total_exp > 0), 1);

        // Restart from DONE with seed 0 behaves as seed 1 and clears counters
        mode = c_M_DELAY;
        pulse_start(32'h0);
        check("seed0_err_clr", err_count, 0);
        wait_done(1000);
        check("seed0_req0", {req_q[0].addr, req_q[0].data, req_q[0].rw}, {32'h0000_100C, 32'h0003_8020, 1'b1});
        check("seed0_pass", {pass, txn_count}, {1'b1, 16'(c_NUM_TXN)});

        // Reset mid-run with a request outstanding
        pulse_start(32'h0000_0077);
        n = 0;
        while (!(txn_count >= 2 && c2m.valid) && n < 200) begin @(negedge clk); n++; end
        check("midrst_setup", (txn_count >= 2 && c2m.valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", c2m.valid, 0);
        check("midrst_flags", {busy, done, pass, timeout}, 4'b0000);
        check("midrst_counts", {err_count, txn_count}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Watchdog: ready never comes
        mode = c_M_NEVER;
        pulse_start(32'h1);
        n = 0;
        while (!c2m.valid && n < 10) begin @(negedge clk); n++; end
        check("to_valid_rise", c2m.valid, 1);
        repeat (15) @(negedge clk);
        check("to_early", {timeout, done}, 2'b00);
        @(negedge clk);
        check("to_flags", {timeout, done, c2m.valid, pass, busy}, 5'b11000);
        check("to_txn", txn_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
